encoder_8to3_seq: RTL
=====================

ENCODER_8TO3_SEQ -- requirements
Module: encoder_8to3_seq

Interface
REQ-001 SHALL have parameter: LSB_FIRST, default 0, priority order (0: bit 7 highest; 1: bit 0 highest).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: D  input  8  request lines, level, synchronous to clk; each rising edge is one event.
REQ-005 SHALL have port: Y  output  3  encoded index of the served request, registered.
REQ-006 SHALL have port: valid  output  1  Y holds an unconsumed code.
REQ-007 SHALL have port: ready  input  1  consumer accepts Y when valid && ready at a clk edge.
REQ-008 SHALL have port: pending  output  8  registered sticky events not yet loaded into Y.
REQ-009 SHALL have port: drop  output  1  one-cycle pulse: an event was lost.

Function
REQ-010 SHALL register D into D_q every edge; event vector E = D & ~D_q.
REQ-011 SHALL update pending each edge as (pending & ~clr) | E, where clr is the one-hot bit loaded into Y that edge; set wins over clear on the same bit.
REQ-012 SHALL select the highest-priority set bit of pending per LSB_FIRST; the selection uses the registered pending value, not E.
REQ-013 SHALL implement FSM with states IDLE and HOLD; valid = (state == HOLD).
REQ-014 IDLE: if pending != 0, load Y with the selected index, clear that bit, go HOLD; else stay IDLE, Y unchanged.
REQ-015 HOLD, ready=0: Y and valid held stable; pending continues to accumulate.
REQ-016 HOLD, ready=1: if pending != 0, load the next selected index and stay HOLD (back-to-back, one code per cycle); else go IDLE.
REQ-017 Latency: D rises before edge k -> pending bit set after edge k -> Y/valid after edge k+1 (if slot free); 2 cycles minimum.
REQ-018 drop SHALL pulse for exactly one cycle, the cycle after the edge at which E has a bit that is already set in pending and not cleared that edge.
REQ-019 Y SHALL change only on a load; it holds its last value in IDLE.
REQ-020 D held high SHALL produce one event only; a new event needs D to go low for at least one sampled cycle.
REQ-021 Simultaneous events on several bits SHALL all be kept and served in priority order, one per accepted transfer.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, valid=0, Y=3'b000, pending=8'h00, drop=0, D_q=8'hFF.
REQ-023 D_q reset to 8'hFF SHALL ensure levels already high at reset release produce no event.
REQ-024 Reset asserted mid-operation SHALL discard Y and all pending events; no code is emitted for them after release.
REQ-025 The first event SHALL be detectable at the second rising edge after rst_n deasserts.

Verification
REQ-026 Single: LSB_FIRST=0, ready=1, D 00->08 -> after 2 edges valid=1, Y=3, pending=00; next cycle valid=0.
REQ-027 Priority burst: D 00->A5 in one cycle, ready=1 -> Y sequence 7,5,2,0 on consecutive cycles, then valid=0; with LSB_FIRST=1 -> 0,2,5,7.
REQ-028 Backpressure: ready=0, D pulses bit 6 then bit 1 -> Y=6 held stable, pending=02; ready=1 for one edge -> Y=1; next accepted -> IDLE.
REQ-029 Drop: ready=0, bit 4 pulsed twice while pending[4]=1 -> drop=1 for one cycle; only one Y=4 is emitted.
REQ-030 Set-vs-clear: new edge on bit 2 at the same edge bit 2 is loaded into Y -> Y=2 and pending[2] remains 1; a second Y=2 follows.
REQ-031 Reset: D=FF through reset release -> no valid; assert rst_n=0 while valid=1, pending=0C -> outputs clear asynchronously, none re-emitted.

Source files
------------

// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: sequential 8-to-3 priority encoder with rising-edge event
// capture, sticky pending requests, a valid/ready handshake on the encoded
// index and a one-cycle drop pulse when a request arrives for a bit that is
// still pending.
module encoder_8to3_seq #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] D,
  input  logic       ready,
  output logic [2:0] Y,
  output logic       valid,
  output logic [7:0] pending,
  output logic       drop
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] d_q;
  logic [7:0] events;
  logic [7:0] clr;
  logic [7:0] pending_next;
  logic [2:0] sel;
  logic       load;

  // Priority pick over the sticky pending vector; the last matching bit in the
  // scan order wins, so the scan runs from lowest to highest priority.
  function automatic logic [2:0] prio_sel(input logic [7:0] req, input bit lsb_first);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (lsb_first) begin
        if (req[7-i]) idx = 3'(7 - i);
        else          idx = idx;
      end else begin
        if (req[i])   idx = 3'(i);
        else          idx = idx;
      end
    end
    return idx;
  endfunction

  // Rising-edge detect against the previous sample of D.
  assign events       = D & ~d_q;
  assign sel          = prio_sel(pending, LSB_FIRST);
  // A new event on a bit wins over the clear of that same bit.
  assign pending_next = (pending & ~clr) | events;
  assign valid        = (state == HOLD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: leave HOLD only when the held code is taken and nothing waits.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pending != 8'h00) state_next = HOLD;
        else                  state_next = IDLE;
      end
      HOLD: begin
        if (ready && (pending == 8'h00)) state_next = IDLE;
        else                             state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/control logic: decide whether a new code is loaded into Y this edge.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = (pending != 8'h00);
      HOLD:    load = ready && (pending != 8'h00);
      default: load = 1'b0;
    endcase
    if (load) clr = 8'h01 << sel;
    else      clr = 8'h00;
  end

  // Datapath registers: input sample, sticky pending, encoded output, drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= 8'hFF;
      pending <= 8'h00;
      Y       <= 3'd0;
      drop    <= 1'b0;
    end else begin
      d_q     <= D;
      pending <= pending_next;
      if (load) Y <= sel;
      else      Y <= Y;
      drop    <= |(events & pending & ~clr);
    end
  end

endmodule
